// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: board clock, standard
// divisor pairs, reset defaults and config field widths.
package clk_div_pkg;

  localparam int unsigned CLK_HZ       = 50_000_000;

  localparam int unsigned UART_DIV     = 326;
  localparam int unsigned UART_HIGH    = 163;
  localparam int unsigned I2C_DIV      = 500;
  localparam int unsigned I2C_HIGH     = 250;

  localparam int unsigned RST_DIV_DEF  = UART_DIV;
  localparam int unsigned RST_HIGH_DEF = UART_HIGH;

  localparam int unsigned DIV_W_DEF    = 16;
  localparam int unsigned CFG_CH_W     = 3;
  localparam int unsigned MAX_CH       = 8;

  // A divisor pair is usable only if the waveform has both a high and a low phase.
  function automatic logic cfg_bad(input int unsigned div, input int unsigned high);
    return (div < 2) || (high == 0) || (high >= div);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divisor registers and
// registered clock-level / period-end tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned RST_DIV  = RST_DIV_DEF,
  parameter int unsigned RST_HIGH = RST_HIGH_DEF
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  input  logic [DIV_W-1:0] load_high_i,
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] act_high_q, act_high_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] pend_high_q, pend_high_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             boundary;

  assign wrap     = (cnt_q == act_div_q - 1'b1);
  assign boundary = !en_i || restart_i || wrap;

  always_comb begin
    cnt_d       = cnt_q;
    act_div_d   = act_div_q;
    act_high_d  = act_high_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_d      = pend_q;
    clk_d       = clk_q;
    tick_d      = tick_q;

    if (!en_i || restart_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else begin
      clk_d  = (cnt_q < act_high_q);
      tick_d = wrap;
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    end

    if (boundary && pend_q) begin
      act_div_d  = pend_div_q;
      act_high_d = pend_high_q;
      pend_d     = 1'b0;
    end

    // A load can only arrive while nothing is pending, so it never collides
    // with the apply above and always waits for the following boundary.
    if (load_i) begin
      pend_d      = 1'b1;
      pend_div_d  = load_div_i;
      pend_high_d = load_high_i;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      act_div_q   <= DIV_W'(RST_DIV);
      act_high_q  <= DIV_W'(RST_HIGH);
      pend_div_q  <= '0;
      pend_high_q <= '0;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      act_div_q   <= act_div_d;
      act_high_q  <= act_high_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: config handshake and validation,
// restart fan-out, one clk_div_chan per channel.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned RST_DIV  = RST_DIV_DEF,
  parameter int unsigned RST_HIGH = RST_HIGH_DEF
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_CH_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  logic [NUM_CH-1:0] pend;
  logic [MAX_CH-1:0] pend_ext;
  logic              ch_ok;
  logic              bad;
  logic              accept;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    pend_ext             = '0;
    pend_ext[NUM_CH-1:0] = pend;
  end

  assign ch_ok     = (32'(cfg_ch) < NUM_CH);
  assign cfg_ready = ch_ok && !pend_ext[cfg_ch];
  assign bad       = cfg_bad(32'(cfg_div), 32'(cfg_high));
  assign accept    = cfg_valid && cfg_ready && !bad;
  assign cfg_err_d = cfg_valid && (!ch_ok || (cfg_ready && bad));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .RST_HIGH(RST_HIGH)
    ) u_chan (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .en_i       (ch_en[g]),
      .restart_i  (sync_restart),
      .load_i     (accept && (cfg_ch == CFG_CH_W'(g))),
      .load_div_i (cfg_div),
      .load_high_i(cfg_high),
      .pend_o     (pend[g]),
      .clk_out_o  (clk_out[g]),
      .tick_o     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: behavioural per-channel period model checked every
// cycle, directed scenarios with hand-derived cycle counts, random traffic.
module tb_clk_div_gen;
  import clk_div_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 16;

  logic            clk_50m = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  ch_en;
  logic            sync_restart;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_ch;
  logic [DW-1:0]   cfg_div;
  logic [DW-1:0]   cfg_high;
  logic            cfg_err;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;

  always #10 clk_50m = ~clk_50m;

  clk_div_gen #(
    .NUM_CH  (NCH),
    .DIV_W   (DW),
    .RST_DIV (326),
    .RST_HIGH(163)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position within the period, active and shadowed divisors.
  int             m_pos  [NCH];
  int             m_div  [NCH];
  int             m_high [NCH];
  int             m_pdiv [NCH];
  int             m_phigh[NCH];
  bit             m_pv   [NCH];
  logic [NCH-1:0] e_clk;
  logic [NCH-1:0] e_tick;
  logic           e_err;
  int             mch, mdv, mhi;
  bit             mrdy, mbad, macc, mlast;

  function automatic bit m_ready(input int ch);
    if (ch >= NCH) return 1'b0;
    return !m_pv[ch];
  endfunction

  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_pos[c] = 0; m_div[c] = 326; m_high[c] = 163; m_pv[c] = 1'b0;
      end
      e_clk = '0; e_tick = '0; e_err = 1'b0;
    end else begin
      mch  = int'(cfg_ch);
      mdv  = int'(cfg_div);
      mhi  = int'(cfg_high);
      mrdy = m_ready(mch);
      mbad = (mdv < 2) || (mhi == 0) || (mhi >= mdv);
      macc = cfg_valid && mrdy && !mbad;
      e_err = cfg_valid && ((mch >= NCH) || (mrdy && mbad));
      for (int c = 0; c < NCH; c++) begin
        mlast = (m_pos[c] == m_div[c] - 1);
        if (!ch_en[c] || sync_restart) begin
          m_pos[c] = 0; e_clk[c] = 1'b0; e_tick[c] = 1'b0;
        end else begin
          e_clk[c]  = (m_pos[c] < m_high[c]);
          e_tick[c] = mlast;
          m_pos[c]  = mlast ? 0 : m_pos[c] + 1;
        end
        if ((!ch_en[c] || sync_restart || mlast) && m_pv[c]) begin
          m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c]; m_pv[c] = 1'b0;
        end
        if (macc && mch == c) begin
          m_pv[c] = 1'b1; m_pdiv[c] = mdv; m_phigh[c] = mhi;
        end
      end
    end
  end

  always @(negedge clk_50m) begin
    if (rst_n === 1'b1) begin
      chk("clk_out", 32'(clk_out), 32'(e_clk));
      chk("tick", 32'(tick), 32'(e_tick));
      chk("cfg_err", 32'(cfg_err), 32'(e_err));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
    end
  end

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic wait_tick(input int c, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[c] && n < lim);
    if (!tick[c]) chk("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic high_run(input int c, output int n);
    n = 0;
    step();
    while (clk_out[c] && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic do_cfg(input int ch, input int dv, input int hi,
                        output logic rdy, output logic err);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = 16'(dv);
    cfg_high  = 16'(hi);
    #1 rdy = cfg_ready;
    @(posedge clk_50m);
    #1;
    err = cfg_err;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, dv;
    logic rdy, err;
    rst_n = 1'b0; ch_en = '0; sync_restart = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_clk_out", 32'(clk_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_cfg_err", 32'(cfg_err), 32'(0));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));

    // Default 326/163 on both channels
    ch_en = 2'b11;
    wait_tick(0, 1000, n); chk("first_tick_cycles", 32'(n), 32'(326));
    chk("both_tick", 32'(tick), 32'(3));
    wait_tick(0, 1000, n); chk("tick_period_326", 32'(n), 32'(326));
    high_run(0, n);        chk("high_163", 32'(n), 32'(163));

    // Shadowed update mid-period on ch1
    wait_tick(1, 1000, n);
    repeat (100) step();
    do_cfg(1, I2C_DIV, I2C_HIGH, rdy, err);
    chk("cfg1_ready_before", 32'(rdy), 32'(1));
    chk("cfg1_err", 32'(err), 32'(0));
    chk("cfg1_ready_pending", 32'(cfg_ready), 32'(0));
    wait_tick(1, 1000, n); chk("old_period_rest", 32'(n), 32'(225));
    chk("cfg1_ready_after", 32'(cfg_ready), 32'(1));
    wait_tick(1, 1000, n); chk("period_500", 32'(n), 32'(500));
    high_run(1, n);        chk("high_250", 32'(n), 32'(250));

    // Rejected configs
    do_cfg(0, 1, 1, rdy, err);   chk("div1_ready", 32'(rdy), 32'(1)); chk("div1_err", 32'(err), 32'(1));
    do_cfg(0, 10, 0, rdy, err);  chk("high0_err", 32'(err), 32'(1));
    do_cfg(0, 10, 10, rdy, err); chk("higheq_err", 32'(err), 32'(1));
    chk("rej_ready", 32'(cfg_ready), 32'(1));
    do_cfg(5, 10, 5, rdy, err);  chk("ch5_ready", 32'(rdy), 32'(0)); chk("ch5_err", 32'(err), 32'(1));
    wait_tick(0, 1000, n);
    wait_tick(0, 1000, n); chk("ch0_unchanged", 32'(n), 32'(326));

    // Phase alignment by sync_restart
    do_cfg(1, 652, 326, rdy, err); chk("cfg652_ready", 32'(rdy), 32'(1));
    wait_tick(1, 1000, n);
    repeat (37) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("restart_clk", 32'(clk_out), 32'(0));
    chk("restart_tick", 32'(tick), 32'(0));
    step();
    chk("restart_rise", 32'(clk_out), 32'(3));
    wait_tick(0, 1000, n); chk("restart_t0", 32'(n), 32'(325));
    chk("restart_t0_only", 32'(tick), 32'(1));
    wait_tick(0, 1000, n); chk("restart_t1", 32'(n), 32'(326));
    chk("restart_aligned", 32'(tick), 32'(3));

    // Pending applied while disabled
    do_cfg(0, I2C_DIV, I2C_HIGH, rdy, err); chk("cfg0_ready", 32'(rdy), 32'(1));
    ch_en = 2'b10;
    step();
    chk("dis_ready", 32'(cfg_ready), 32'(1));
    chk("dis_clk", 32'(clk_out[0]), 32'(0));
    ch_en = 2'b11;
    wait_tick(0, 1000, n); chk("reen_500", 32'(n), 32'(500));

    // Random traffic
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 99) < 2) ch_en = NCH'($urandom);
      sync_restart = ($urandom_range(0, 199) == 0);
      cfg_valid    = ($urandom_range(0, 99) < 8);
      cfg_ch       = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, NCH - 1)) : 3'($urandom_range(0, 7));
      dv           = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 700) : $urandom_range(0, 40);
      cfg_div      = 16'(dv);
      cfg_high     = 16'($urandom_range(0, dv + 1));
      step();
    end
    cfg_valid = 1'b0; sync_restart = 1'b0; ch_en = 2'b11; cfg_ch = '0;

    // Reset mid-period with a pending update
    n = 0;
    while (!cfg_ready && n < 2000) begin step(); n++; end
    do_cfg(0, 40, 20, rdy, err); chk("pre_rst_ready", 32'(rdy), 32'(1));
    repeat (5) step();
    #5 rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_out), 32'(0));
    chk("arst_tick", 32'(tick), 32'(0));
    chk("arst_err", 32'(cfg_err), 32'(0));
    step(); step();
    rst_n = 1'b1;
    chk("post_rst_ready", 32'(cfg_ready), 32'(1));
    wait_tick(0, 1000, n); chk("post_rst_326", 32'(n), 32'(326));
    high_run(0, n);        chk("post_rst_163", 32'(n), 32'(163));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
